// File: rtl/rtlinf_pkg.sv
// Shared definitions for the job sequencer: FSM state encoding and watchdog defaults.
package rtlinf_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int WDOG_WIDTH             = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSIGN_ACT,
    ST_ASSIGN_WGT,
    ST_CONFIG,
    ST_WAIT,
    ST_UNASSIGN_ACT,
    ST_UNASSIGN_WGT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/rtlinf_job_sequencer_if.sv
// Job descriptor handshake between a job producer (master) and the sequencer (slave).
interface rtlinf_job_sequencer_if #(
  parameter int LOG_NUM_KERNELS         = 1,
  parameter int LOG_NUM_ACT_MEMORIES    = 1,
  parameter int LOG_NUM_WEIGHT_MEMORIES = 1,
  parameter int LOG_MAX_ITERS           = 8,
  parameter int LOG_MAX_READS_PER_ITER  = 8,
  parameter int DATA_WIDTH              = 8
);
  logic                               job_valid;
  logic                               job_ready;
  logic [LOG_NUM_KERNELS-1:0]         job_kernel;
  logic [LOG_NUM_ACT_MEMORIES-1:0]    job_act_mem;
  logic [LOG_NUM_WEIGHT_MEMORIES-1:0] job_weight_mem;
  logic [LOG_MAX_ITERS-1:0]           job_num_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0]  job_num_reads;
  logic                               job_mode_in;
  logic                               job_mode_out;
  logic [DATA_WIDTH-1:0]              job_min_clip;
  logic [DATA_WIDTH-1:0]              job_max_clip;

  modport master (
    output job_valid, job_kernel, job_act_mem, job_weight_mem, job_num_iters,
           job_num_reads, job_mode_in, job_mode_out, job_min_clip, job_max_clip,
    input  job_ready
  );

  modport slave (
    input  job_valid, job_kernel, job_act_mem, job_weight_mem, job_num_iters,
           job_num_reads, job_mode_in, job_mode_out, job_min_clip, job_max_clip,
    output job_ready
  );
endinterface

// File: rtl/rtlinf_watchdog.sv
// Free-running cycle counter that flags when it reaches limit-1 while enabled.
module rtlinf_watchdog #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = enable && (count == (limit - WIDTH'(1)));

endmodule

// File: rtl/rtlinf_job_sequencer.sv
// Sequences one job at a time: assign memories, configure the kernel, wait for completion
// (with watchdog), release memories and report done/error.
module rtlinf_job_sequencer
  import rtlinf_pkg::*;
#(
  parameter int NUM_KERNELS             = 2,
  parameter int LOG_NUM_KERNELS         = 1,
  parameter int LOG_NUM_ACT_MEMORIES    = 1,
  parameter int LOG_NUM_WEIGHT_MEMORIES = 1,
  parameter int LOG_MAX_ITERS           = 8,
  parameter int LOG_MAX_READS_PER_ITER  = 8,
  parameter int DATA_WIDTH              = 8,
  parameter int TIMEOUT_CYCLES          = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               rst,
  rtlinf_job_sequencer_if.slave              job,
  input  logic [NUM_KERNELS-1:0]             kernel_done,

  output logic                               cmd_act_assign,
  output logic                               cmd_act_unassign,
  output logic [LOG_NUM_KERNELS:0]           cmd_act_read_port,
  output logic [LOG_NUM_KERNELS:0]           cmd_act_write_port,
  output logic [LOG_NUM_ACT_MEMORIES-1:0]    cmd_act_memory,

  output logic                               cmd_weight_assign,
  output logic                               cmd_weight_unassign,
  output logic [LOG_NUM_KERNELS-1:0]         cmd_weight_read_port,
  output logic                               cmd_weight_write_port,
  output logic [LOG_NUM_WEIGHT_MEMORIES-1:0] cmd_weight_memory,

  output logic [NUM_KERNELS-1:0]             configure,
  output logic [LOG_MAX_ITERS-1:0]           num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0]  num_reads_per_iter,
  output logic                               conf_mode_in,
  output logic                               conf_mode_out,
  output logic [DATA_WIDTH-1:0]              min_clip,
  output logic [DATA_WIDTH-1:0]              max_clip,

  output logic                               job_done,
  output logic                               job_error,
  output logic                               busy
);

  localparam logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES);

  seq_state_t                         state, state_nxt;
  logic [LOG_NUM_KERNELS-1:0]         kernel_q;
  logic [LOG_NUM_ACT_MEMORIES-1:0]    act_mem_q;
  logic [LOG_NUM_WEIGHT_MEMORIES-1:0] wgt_mem_q;
  logic                               err_q;

  logic accept;
  logic done_hit;
  logic wdog_expired;
  logic timeout;
  logic act_sel;
  logic wgt_sel;

  assign job.job_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign accept        = job.job_valid && (state == ST_IDLE);
  assign done_hit      = kernel_done[kernel_q];
  assign timeout       = (state == ST_WAIT) && wdog_expired && !done_hit;

  rtlinf_watchdog #(.WIDTH(WDOG_WIDTH)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_CONFIG),
    .enable  (state == ST_WAIT),
    .limit   (WDOG_LIMIT),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      kernel_q           <= '0;
      act_mem_q          <= '0;
      wgt_mem_q          <= '0;
      err_q              <= 1'b0;
      num_iters          <= '0;
      num_reads_per_iter <= '0;
      conf_mode_in       <= 1'b0;
      conf_mode_out      <= 1'b0;
      min_clip           <= '0;
      max_clip           <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        kernel_q           <= job.job_kernel;
        act_mem_q          <= job.job_act_mem;
        wgt_mem_q          <= job.job_weight_mem;
        err_q              <= 1'b0;
        num_iters          <= job.job_num_iters;
        num_reads_per_iter <= job.job_num_reads;
        conf_mode_in       <= job.job_mode_in;
        conf_mode_out      <= job.job_mode_out;
        min_clip           <= job.job_min_clip;
        max_clip           <= job.job_max_clip;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:         if (accept) state_nxt = ST_ASSIGN_ACT;
      ST_ASSIGN_ACT:   state_nxt = ST_ASSIGN_WGT;
      ST_ASSIGN_WGT:   state_nxt = (num_iters == '0) ? ST_UNASSIGN_ACT : ST_CONFIG;
      ST_CONFIG:       state_nxt = ST_WAIT;
      ST_WAIT:         if (done_hit || wdog_expired) state_nxt = ST_UNASSIGN_ACT;
      ST_UNASSIGN_ACT: state_nxt = ST_UNASSIGN_WGT;
      ST_UNASSIGN_WGT: state_nxt = ST_DONE;
      ST_DONE:         state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  // Port/memory fields are driven only alongside their pulse and are zero otherwise.
  assign act_sel = (state == ST_ASSIGN_ACT) || (state == ST_UNASSIGN_ACT);
  assign wgt_sel = (state == ST_ASSIGN_WGT) || (state == ST_UNASSIGN_WGT);

  always_comb begin
    cmd_act_assign       = (state == ST_ASSIGN_ACT);
    cmd_act_unassign     = (state == ST_UNASSIGN_ACT);
    cmd_act_read_port    = '0;
    cmd_act_write_port   = '0;
    cmd_act_memory       = '0;
    cmd_weight_assign    = (state == ST_ASSIGN_WGT);
    cmd_weight_unassign  = (state == ST_UNASSIGN_WGT);
    cmd_weight_read_port = '0;
    cmd_weight_memory    = '0;
    configure            = '0;
    job_done             = (state == ST_DONE);
    job_error            = (state == ST_DONE) && err_q;

    if (act_sel) begin
      cmd_act_read_port  = {1'b0, kernel_q};
      cmd_act_write_port = {1'b0, kernel_q};
      cmd_act_memory     = act_mem_q;
    end
    if (wgt_sel) begin
      cmd_weight_read_port = kernel_q;
      cmd_weight_memory    = wgt_mem_q;
    end
    if (state == ST_CONFIG) begin
      configure[kernel_q] = 1'b1;
    end
  end

  assign cmd_weight_write_port = 1'b0;

endmodule

// File: tb/tb_rtlinf_job_sequencer.sv
// Directed bench for rtlinf_job_sequencer: expected command pulses are queued with their
// cycle number when a job is driven and compared whenever the DUT emits any pulse.
module tb_rtlinf_job_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rtlinf_job_sequencer_if job_bus ();

  logic [1:0] kernel_done;
  logic       cmd_act_assign, cmd_act_unassign;
  logic [1:0] cmd_act_read_port, cmd_act_write_port;
  logic       cmd_act_memory;
  logic       cmd_weight_assign, cmd_weight_unassign;
  logic       cmd_weight_read_port, cmd_weight_write_port, cmd_weight_memory;
  logic [1:0] configure;
  logic [7:0] num_iters, num_reads_per_iter;
  logic       conf_mode_in, conf_mode_out;
  logic [7:0] min_clip, max_clip;
  logic       job_done, job_error, busy;

  rtlinf_job_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .job                   (job_bus.slave),
    .kernel_done           (kernel_done),
    .cmd_act_assign        (cmd_act_assign),
    .cmd_act_unassign      (cmd_act_unassign),
    .cmd_act_read_port     (cmd_act_read_port),
    .cmd_act_write_port    (cmd_act_write_port),
    .cmd_act_memory        (cmd_act_memory),
    .cmd_weight_assign     (cmd_weight_assign),
    .cmd_weight_unassign   (cmd_weight_unassign),
    .cmd_weight_read_port  (cmd_weight_read_port),
    .cmd_weight_write_port (cmd_weight_write_port),
    .cmd_weight_memory     (cmd_weight_memory),
    .configure             (configure),
    .num_iters             (num_iters),
    .num_reads_per_iter    (num_reads_per_iter),
    .conf_mode_in          (conf_mode_in),
    .conf_mode_out         (conf_mode_out),
    .min_clip              (min_clip),
    .max_clip              (max_clip),
    .job_done              (job_done),
    .job_error             (job_error),
    .busy                  (busy)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        act_a;
    logic        act_u;
    logic [1:0]  act_rp;
    logic [1:0]  act_wp;
    logic        act_m;
    logic        w_a;
    logic        w_u;
    logic        w_rp;
    logic        w_wp;
    logic        w_m;
    logic [1:0]  conf;
    logic        done;
    logic        err;
  } ev_t;

  typedef struct {
    ev_t   ev;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input string tag, input ev_t e);
    exp_t x;
    x.ev  = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic exp_act(input int c, input bit unassign, input logic k, input logic m);
    ev_t e = '0;
    e.cyc    = 32'(c);
    e.act_a  = !unassign;
    e.act_u  = unassign;
    e.act_rp = {1'b0, k};
    e.act_wp = {1'b0, k};
    e.act_m  = m;
    push_ev(unassign ? "act_unassign" : "act_assign", e);
  endtask

  task automatic exp_wgt(input int c, input bit unassign, input logic k, input logic m);
    ev_t e = '0;
    e.cyc  = 32'(c);
    e.w_a  = !unassign;
    e.w_u  = unassign;
    e.w_rp = k;
    e.w_m  = m;
    push_ev(unassign ? "wgt_unassign" : "wgt_assign", e);
  endtask

  task automatic exp_cfg(input int c, input logic k);
    ev_t e = '0;
    e.cyc  = 32'(c);
    e.conf = k ? 2'b10 : 2'b01;
    push_ev("configure", e);
  endtask

  task automatic exp_done(input int c, input logic er);
    ev_t e = '0;
    e.cyc  = 32'(c);
    e.done = 1'b1;
    e.err  = er;
    push_ev("job_done", e);
  endtask

  // Any cycle with a nonzero pulse or field must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t  o;
    exp_t x;
    if (mon_en) begin
      o        = '0;
      o.cyc    = 32'(cyc);
      o.act_a  = cmd_act_assign;
      o.act_u  = cmd_act_unassign;
      o.act_rp = cmd_act_read_port;
      o.act_wp = cmd_act_write_port;
      o.act_m  = cmd_act_memory;
      o.w_a    = cmd_weight_assign;
      o.w_u    = cmd_weight_unassign;
      o.w_rp   = cmd_weight_read_port;
      o.w_wp   = cmd_weight_write_port;
      o.w_m    = cmd_weight_memory;
      o.conf   = configure;
      o.done   = job_done;
      o.err    = job_error;
      if (o[15:0] !== 16'h0) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_event: observed=%h expected=none", o);
        end
        if (sb.size() > 0) begin
          x = sb.pop_front();
          assert (o === x.ev) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", x.tag, o, x.ev);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    int n = 0;
    while (cyc < c && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_done(input logic [1:0] v, output int d);
    kernel_done = v;
    d = cyc;
    step();
    kernel_done = 2'b00;
  endtask

  task automatic send_job(input logic k, input logic am, input logic wm,
                          input logic [7:0] it, input logic [7:0] rd,
                          input logic mi, input logic mo,
                          input logic [7:0] mn, input logic [7:0] mx, output int t);
    int n = 0;
    while (job_bus.job_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("ready_before_job", 32'(job_bus.job_ready), 32'd1);
    job_bus.job_valid      = 1'b1;
    job_bus.job_kernel     = k;
    job_bus.job_act_mem    = am;
    job_bus.job_weight_mem = wm;
    job_bus.job_num_iters  = it;
    job_bus.job_num_reads  = rd;
    job_bus.job_mode_in    = mi;
    job_bus.job_mode_out   = mo;
    job_bus.job_min_clip   = mn;
    job_bus.job_max_clip   = mx;
    t = cyc;
    step();
    job_bus.job_valid = 1'b0;
    exp_act(t + 1, 1'b0, k, am);
    exp_wgt(t + 2, 1'b0, k, wm);
    if (it != 8'd0) begin
      exp_cfg(t + 3, k);
    end else begin
      exp_act(t + 3, 1'b1, k, am);
      exp_wgt(t + 4, 1'b1, k, wm);
      exp_done(t + 5, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int t;
    int d;
    job_bus.job_valid      = 1'b0;
    job_bus.job_kernel     = 1'b0;
    job_bus.job_act_mem    = 1'b0;
    job_bus.job_weight_mem = 1'b0;
    job_bus.job_num_iters  = 8'd0;
    job_bus.job_num_reads  = 8'd0;
    job_bus.job_mode_in    = 1'b0;
    job_bus.job_mode_out   = 1'b0;
    job_bus.job_min_clip   = 8'd0;
    job_bus.job_max_clip   = 8'd0;
    kernel_done            = 2'b00;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    check("reset_job_ready", 32'(job_bus.job_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_num_iters", 32'(num_iters), 32'd0);
    check("reset_max_clip", 32'(max_clip), 32'd0);

    // Completion pulses while idle are ignored
    pulse_done(2'b11, d);
    step();
    check("idle_done_ignored_ready", 32'(job_bus.job_ready), 32'd1);

    // Job 1: kernel 1, nominal completion, wrong-kernel pulse in WAIT ignored
    send_job(1'b1, 1'b1, 1'b0, 8'd2, 8'd16, 1'b0, 1'b1, 8'h10, 8'hF0, t);
    check("job1_busy", 32'(busy), 32'd1);
    check("job1_ready_low", 32'(job_bus.job_ready), 32'd0);
    check("job1_num_iters", 32'(num_iters), 32'd2);
    check("job1_num_reads", 32'(num_reads_per_iter), 32'd16);
    check("job1_modes", {30'd0, conf_mode_in, conf_mode_out}, 32'b01);
    check("job1_clips", {16'd0, min_clip, max_clip}, 32'h10F0);
    goto(t + 5);
    pulse_done(2'b01, d);
    goto(t + 7);
    check("job1_still_waiting", 32'(busy), 32'd1);
    pulse_done(2'b10, d);
    exp_act(d + 1, 1'b1, 1'b1, 1'b1);
    exp_wgt(d + 2, 1'b1, 1'b1, 1'b0);
    exp_done(d + 3, 1'b0);
    goto(d + 3);
    check("job1_ready_at_done", 32'(job_bus.job_ready), 32'd0);
    goto(d + 4);
    check("job1_ready_after", 32'(job_bus.job_ready), 32'd1);
    check("job1_iters_held", 32'(num_iters), 32'd2);

    // Job 2: kernel 0, watchdog expiry after 8 WAIT cycles, other-kernel pulse ignored
    send_job(1'b0, 1'b0, 1'b1, 8'd1, 8'd4, 1'b1, 1'b0, 8'h01, 8'h7F, t);
    goto(t + 6);
    pulse_done(2'b10, d);
    exp_act(t + 12, 1'b1, 1'b0, 1'b0);
    exp_wgt(t + 13, 1'b1, 1'b0, 1'b1);
    exp_done(t + 14, 1'b1);
    goto(t + 11);
    check("job2_wait_last_cycle", 32'(busy), 32'd1);
    goto(t + 15);
    check("job2_ready_after", 32'(job_bus.job_ready), 32'd1);

    // Job 3: zero iterations skips CONFIG/WAIT; error from job 2 must not carry over
    send_job(1'b1, 1'b0, 1'b1, 8'd0, 8'd8, 1'b0, 1'b0, 8'h00, 8'hFF, t);
    goto(t + 3);
    pulse_done(2'b10, d);
    goto(t + 6);
    check("job3_ready_after", 32'(job_bus.job_ready), 32'd1);

    // Job 4: completion on the very first WAIT cycle
    send_job(1'b0, 1'b1, 1'b0, 8'd5, 8'd1, 1'b1, 1'b1, 8'h22, 8'h33, t);
    goto(t + 4);
    pulse_done(2'b01, d);
    exp_act(d + 1, 1'b1, 1'b0, 1'b1);
    exp_wgt(d + 2, 1'b1, 1'b0, 1'b0);
    exp_done(d + 3, 1'b0);
    goto(d + 4);
    check("job4_ready_after", 32'(job_bus.job_ready), 32'd1);
    check("job4_iters_held", 32'(num_iters), 32'd5);

    // Job 5: reset while waiting abandons the job without unassigns
    send_job(1'b1, 1'b1, 1'b1, 8'd3, 8'd9, 1'b1, 1'b1, 8'h44, 8'h55, t);
    goto(t + 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_job_ready", 32'(job_bus.job_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_num_iters", 32'(num_iters), 32'd0);
    check("rst_conf_regs", {num_reads_per_iter, min_clip, max_clip, 6'd0, conf_mode_in, conf_mode_out}, 32'd0);
    goto(t + 16);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
